title_scene_ctrl: RTL and testbench

Scene sequencer and fade controller for the title/game display path. It counts VGA frames, steps a 4-bit brightness for fade-in and fade-out, and selects which scene's pixel source reaches the screen. It also gates game logic and blinks the "press start" overlay. It sits between the per-scene renderers and the VGA output, scaling the selected 4:4:4 RGB by the current brightness.

---
 rtl/title_pkg.sv | 33 +++
 rtl/color_scaler.sv | 31 +++
 rtl/title_scene_ctrl.sv | 178 +++++++++++++++++
 tb/tb_title_scene_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/title_pkg.sv
// Shared types and helpers for the title/game scene sequencer.
package title_pkg;

  typedef enum logic [2:0] {
    T_IN   = 3'd0,
    T_SHOW = 3'd1,
    T_OUT  = 3'd2,
    G_IN   = 3'd3,
    G_RUN  = 3'd4,
    G_OUT  = 3'd5
  } scene_state_e;

  typedef enum logic {
    SCENE_TITLE = 1'b0,
    SCENE_GAME  = 1'b1
  } scene_e;

  localparam logic [3:0] BRIGHT_MAX = 4'd15;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  // One channel scaled by level/15, truncated; the 8-bit product tops out at 225.
  function automatic logic [3:0] scale_ch(input logic [3:0] c, input logic [3:0] lvl);
    logic [7:0] prod;
    prod = 8'(c) * 8'(lvl);
    return 4'(prod / 8'd15);
  endfunction

endpackage

// File: rtl/color_scaler.sv
// Registered 3-channel brightness scaler with blanking; one cycle of latency.
module color_scaler
  import title_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       blank,
  input  logic [3:0] level,
  input  rgb_t       pix_in,
  output rgb_t       pix_out
);

  rgb_t pix_d, pix_q;

  always_comb begin
    pix_d = '0;
    if (blank) begin
      pix_d.r = scale_ch(pix_in.r, level);
      pix_d.g = scale_ch(pix_in.g, level);
      pix_d.b = scale_ch(pix_in.b, level);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pix_q <= '0;
    else        pix_q <= pix_d;
  end

  assign pix_out = pix_q;

endmodule

// File: rtl/title_scene_ctrl.sv
// Title/game scene sequencer with frame-rate fades, start-key edge detect and blink overlay.
// Define FADE_BYPASS_EN to make every fade complete on the first frame tick after entry.
module title_scene_ctrl
  import title_pkg::*;
#(
  parameter int unsigned FADE_STEP_FRAMES = 4,
  parameter int unsigned BLINK_FRAMES     = 30
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic       vsync,
  input  logic       blank,
  input  logic       start_key,
  input  logic       game_over,
  input  logic [3:0] red_in,
  input  logic [3:0] green_in,
  input  logic [3:0] blue_in,
  output logic       scene_sel,
  output logic       game_run,
  output logic       blink_on,
  output logic [3:0] brightness,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue
);

  localparam int unsigned STEP_W  = $clog2(FADE_STEP_FRAMES + 1);
  localparam int unsigned BLINK_W = $clog2(BLINK_FRAMES + 1);
  localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(FADE_STEP_FRAMES - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

  scene_state_e        state_q, state_d;
  scene_e              scene_q, scene_d;
  logic [3:0]          bright_q, bright_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
  logic                blink_q, blink_d;
  logic                run_q, run_d;
  logic                vsync_q, start_q, start_d;

  logic                frame_tick_c;
  logic                step_wrap_c;
  logic [3:0]          bright_up_c, bright_dn_c;

  assign frame_tick_c = vsync_q & ~vsync;

  // Candidate brightness for this tick in a fade-in or fade-out state.
  always_comb begin
`ifdef FADE_BYPASS_EN
    step_wrap_c = 1'b1;
    bright_up_c = BRIGHT_MAX;
    bright_dn_c = 4'd0;
`else
    step_wrap_c = (step_q == STEP_LAST);
    bright_up_c = bright_q;
    bright_dn_c = bright_q;
    if (step_wrap_c && bright_q != BRIGHT_MAX) bright_up_c = bright_q + 4'd1;
    if (step_wrap_c && bright_q != 4'd0)       bright_dn_c = bright_q - 4'd1;
`endif
  end

  always_comb begin
    state_d     = state_q;
    scene_d     = scene_q;
    bright_d    = bright_q;
    step_d      = step_q;
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    run_d       = run_q;
    start_d     = frame_tick_c ? start_key : start_q;

    case (state_q)
      T_IN, G_IN: begin
        if (frame_tick_c) begin
          bright_d = bright_up_c;
          step_d   = step_wrap_c ? '0 : step_q + STEP_W'(1);
          if (bright_d == BRIGHT_MAX) begin
            step_d = '0;
            if (state_q == T_IN) begin
              state_d     = T_SHOW;
              blink_d     = 1'b1;
              blink_cnt_d = '0;
            end else begin
              state_d = G_RUN;
              run_d   = 1'b1;
            end
          end
        end
      end
      T_SHOW: begin
        if (frame_tick_c) begin
          if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_d     = ~blink_q;
          end else begin
            blink_cnt_d = blink_cnt_q + BLINK_W'(1);
          end
          // Rising edge at frame rate: a key already held at the previous tick is ignored.
          if (start_key && !start_q) begin
            state_d = T_OUT;
            step_d  = '0;
            blink_d = 1'b0;
          end
        end
      end
      T_OUT, G_OUT: begin
        if (frame_tick_c) begin
          bright_d = bright_dn_c;
          step_d   = step_wrap_c ? '0 : step_q + STEP_W'(1);
          if (bright_d == 4'd0) begin
            step_d = '0;
            if (state_q == T_OUT) begin
              state_d = G_IN;
              scene_d = SCENE_GAME;
            end else begin
              state_d = T_IN;
              scene_d = SCENE_TITLE;
            end
          end
        end
      end
      G_RUN: begin
        if (game_over) begin
          state_d = G_OUT;
          run_d   = 1'b0;
          step_d  = '0;
        end
      end
      default: state_d = T_IN;
    endcase
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= T_IN;
      scene_q     <= SCENE_TITLE;
      bright_q    <= 4'd0;
      step_q      <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      run_q       <= 1'b0;
      vsync_q     <= 1'b1;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      scene_q     <= scene_d;
      bright_q    <= bright_d;
      step_q      <= step_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      run_q       <= run_d;
      vsync_q     <= vsync;
      start_q     <= start_d;
    end
  end

  rgb_t pix_in_c, pix_out;

  assign pix_in_c = '{r: red_in, g: green_in, b: blue_in};

  color_scaler u_color_scaler (
    .clk     (vga_clk),
    .rst_n   (reset_n),
    .blank   (blank),
    .level   (bright_q),
    .pix_in  (pix_in_c),
    .pix_out (pix_out)
  );

  assign scene_sel  = scene_q;
  assign game_run   = run_q;
  assign blink_on   = blink_q;
  assign brightness = bright_q;
  assign red        = pix_out.r;
  assign green      = pix_out.g;
  assign blue       = pix_out.b;

endmodule

// File: tb/tb_title_scene_ctrl.sv
// Bench for title_scene_ctrl with FADE_STEP_FRAMES=2, BLINK_FRAMES=3 and two-cycle frames.
module tb_title_scene_ctrl;

  logic       vga_clk = 1'b0;
  logic       reset_n, vsync, blank, start_key, game_over;
  logic [3:0] red_in, green_in, blue_in;
  logic       scene_sel, game_run, blink_on;
  logic [3:0] brightness, red, green, blue;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } pix_t;

  typedef struct {
    logic [3:0] lvl;
    logic       blk;
    pix_t       in;
    pix_t       exp;
  } vec_t;

  vec_t vecs[8];
  pix_t exp_q[$];

  title_scene_ctrl #(
    .FADE_STEP_FRAMES (2),
    .BLINK_FRAMES     (3)
  ) dut (
    .vga_clk    (vga_clk),
    .reset_n    (reset_n),
    .vsync      (vsync),
    .blank      (blank),
    .start_key  (start_key),
    .game_over  (game_over),
    .red_in     (red_in),
    .green_in   (green_in),
    .blue_in    (blue_in),
    .scene_sel  (scene_sel),
    .game_run   (game_run),
    .blink_on   (blink_on),
    .brightness (brightness),
    .red        (red),
    .green      (green),
    .blue       (blue)
  );

  always #5 vga_clk = ~vga_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One frame: vsync low for one cycle, high for one cycle; returns at a falling clock edge.
  task automatic tick();
    @(negedge vga_clk);
    vsync = 1'b0;
    @(negedge vga_clk);
    vsync = 1'b1;
  endtask

  task automatic fade(input bit up, input int k_from, input int k_to);
    for (int k = k_from + 1; k <= k_to; k++) begin
      tick();
      chk(up ? "fade_in_bright" : "fade_out_bright", int'(brightness), up ? k / 2 : 15 - k / 2);
    end
  endtask

  task automatic run_vecs(input logic [3:0] lvl);
    pix_t got;
    foreach (vecs[i]) begin
      if (vecs[i].lvl == lvl) begin
        red_in   = vecs[i].in.r;
        green_in = vecs[i].in.g;
        blue_in  = vecs[i].in.b;
        blank    = vecs[i].blk;
        exp_q.push_back(vecs[i].exp);
        @(negedge vga_clk);
        got = '{r: red, g: green, b: blue};
        if (exp_q.size() == 0) begin
          chk("pix_queue_empty", 1, 0);
        end else begin
          chk("pix", int'(got), int'(exp_q.pop_front()));
        end
      end
    end
    blank = 1'b1;
  endtask

  initial begin
    vecs[0] = '{4'd15, 1'b1, '{4'hF, 4'h8, 4'h1}, '{4'hF, 4'h8, 4'h1}};
    vecs[1] = '{4'd15, 1'b1, '{4'h3, 4'hA, 4'h5}, '{4'h3, 4'hA, 4'h5}};
    vecs[2] = '{4'd15, 1'b0, '{4'hF, 4'hF, 4'hF}, '{4'h0, 4'h0, 4'h0}};
    vecs[3] = '{4'd7,  1'b1, '{4'hF, 4'h8, 4'h1}, '{4'h7, 4'h3, 4'h0}};
    vecs[4] = '{4'd7,  1'b1, '{4'h9, 4'h5, 4'hC}, '{4'h4, 4'h2, 4'h5}};
    vecs[5] = '{4'd7,  1'b0, '{4'h9, 4'h5, 4'hC}, '{4'h0, 4'h0, 4'h0}};
    vecs[6] = '{4'd0,  1'b1, '{4'hF, 4'hF, 4'hF}, '{4'h0, 4'h0, 4'h0}};
    vecs[7] = '{4'd9,  1'b1, '{4'hF, 4'h8, 4'h1}, '{4'h9, 4'h4, 4'h0}};

    reset_n = 1'b0; vsync = 1'b1; blank = 1'b1; start_key = 1'b0; game_over = 1'b0;
    red_in = 4'hF; green_in = 4'h8; blue_in = 4'h1;
    repeat (3) @(negedge vga_clk);
    chk("rst_bright", int'(brightness), 0);
    chk("rst_scene", int'(scene_sel), 0);
    chk("rst_run", int'(game_run), 0);
    chk("rst_blink", int'(blink_on), 0);
    chk("rst_rgb", int'({red, green, blue}), 0);
    reset_n = 1'b1;
    run_vecs(4'd0);

    // Title fade-in, then blink behaviour in T_SHOW.
    fade(1'b1, 0, 29);
    chk("blink_before_show", int'(blink_on), 0);
    fade(1'b1, 29, 30);
    chk("blink_show_entry", int'(blink_on), 1);
    run_vecs(4'd15);
    tick(); tick();
    chk("blink_hold", int'(blink_on), 1);
    tick();
    chk("blink_toggle", int'(blink_on), 0);
    chk("show_bright", int'(brightness), 15);

    // Start press, title fade-out, switch to game scene.
    start_key = 1'b1;
    tick();
    chk("start_leaves_show", int'(blink_on), 0);
    start_key = 1'b0;
    fade(1'b0, 0, 16);
    run_vecs(4'd7);
    fade(1'b0, 16, 29);
    chk("scene_before_black", int'(scene_sel), 0);
    fade(1'b0, 29, 30);
    chk("scene_game_at_black", int'(scene_sel), 1);
    run_vecs(4'd0);

    // Game fade-in; a stray game_over here must be ignored.
    fade(1'b1, 0, 10);
    @(negedge vga_clk); game_over = 1'b1;
    @(negedge vga_clk); game_over = 1'b0;
    chk("gin_gameover_ignored", int'(game_run), 0);
    fade(1'b1, 10, 29);
    chk("run_before_full", int'(game_run), 0);
    fade(1'b1, 29, 30);
    chk("run_at_full", int'(game_run), 1);
    tick(); tick();
    chk("run_holds", int'(game_run), 1);

    // game_over coincident with a frame tick.
    @(negedge vga_clk); vsync = 1'b0; game_over = 1'b1;
    @(negedge vga_clk); vsync = 1'b1; game_over = 1'b0;
    chk("run_drops", int'(game_run), 0);
    chk("gout_start_bright", int'(brightness), 15);
    fade(1'b0, 0, 29);
    chk("gout_scene_before_black", int'(scene_sel), 1);
    fade(1'b0, 29, 30);
    chk("scene_title_at_black", int'(scene_sel), 0);

    // Key held through reset must be released before it counts.
    @(negedge vga_clk); start_key = 1'b1; reset_n = 1'b0;
    @(negedge vga_clk); reset_n = 1'b1;
    fade(1'b1, 0, 30);
    chk("held_show_entry", int'(blink_on), 1);
    repeat (5) tick();
    chk("held_no_start", int'(brightness), 15);
    chk("held_blink", int'(blink_on), 0);
    start_key = 1'b0;
    tick();
    chk("release_still_show", int'(blink_on), 1);
    start_key = 1'b1;
    tick();
    chk("press_after_release", int'(blink_on), 0);
    start_key = 1'b0;
    fade(1'b0, 0, 30);
    chk("held_scene_game", int'(scene_sel), 1);

    // Async reset mid game fade-in at brightness 9.
    fade(1'b1, 0, 18);
    run_vecs(4'd9);
    red_in = 4'hF; green_in = 4'h8; blue_in = 4'h1;
    @(negedge vga_clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async_bright", int'(brightness), 0);
    chk("async_scene", int'(scene_sel), 0);
    chk("async_rgb", int'({red, green, blue}), 0);
    chk("async_blink_run", int'({blink_on, game_run}), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
